// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner tag and size constants for the memory arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;
   localparam logic [1:0] SIZE_WORD = 2'b11;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: fixed data-first priority with a starvation escape for fetch
module mem_arb_prio #(
   parameter int STARVE_MAX = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic i_req,
   input  logic d_req,
   output logic i_gnt,
   output logic d_gnt
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   logic [CW-1:0] starve_cnt;
   assign i_gnt = reset && i_req && (!d_req || starve_cnt == CW'(STARVE_MAX));
   assign d_gnt = reset && d_req && !i_gnt;
   always_ff @(posedge clock) begin
      if (!reset || !i_req || i_gnt)
         starve_cnt <= '0;
      else if (starve_cnt != CW'(STARVE_MAX))
         starve_cnt <= starve_cnt + 1'b1;
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data_memory port between fetch and load/store,
// registering the winner onto the memory bus and steering read data back
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_req_in,
   input  logic [ADDR_W-1:0] i_addr_in,
   output logic              i_gnt_out,
   output logic              i_rvalid_out,
   output logic [DATA_W-1:0] i_rdata_out,
   input  logic              d_req_in,
   input  logic              d_we_in,
   input  logic [ADDR_W-1:0] d_addr_in,
   input  logic [DATA_W-1:0] d_wdata_in,
   input  logic [1:0]        d_size_in,
   output logic              d_gnt_out,
   output logic              d_rvalid_out,
   output logic [DATA_W-1:0] d_rdata_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [DATA_W-1:0] mem_wdata_out,
   output logic              mem_re_out,
   output logic              mem_we_out,
   output logic [1:0]        mem_size_out,
   input  logic [DATA_W-1:0] mem_rdata_in
);
   owner_t tag_issue, tag_ret;
   mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
      .clock (clock),
      .reset (reset),
      .i_req (i_req_in),
      .d_req (d_req_in),
      .i_gnt (i_gnt_out),
      .d_gnt (d_gnt_out)
   );
   always_ff @(posedge clock) begin
      if (!reset) begin
         mem_re_out    <= 1'b0;
         mem_we_out    <= 1'b0;
         mem_addr_out  <= '0;
         mem_wdata_out <= '0;
         mem_size_out  <= SIZE_WORD;
         tag_issue     <= OWN_NONE;
         tag_ret       <= OWN_NONE;
      end else begin
         mem_re_out <= i_gnt_out || (d_gnt_out && !d_we_in);
         mem_we_out <= d_gnt_out && d_we_in;
         tag_issue  <= i_gnt_out ? OWN_I : (d_gnt_out && !d_we_in) ? OWN_D : OWN_NONE;
         tag_ret    <= tag_issue;
         if (i_gnt_out) begin
            mem_addr_out  <= i_addr_in;
            mem_wdata_out <= '0;
            mem_size_out  <= SIZE_WORD;
         end else if (d_gnt_out) begin
            mem_addr_out  <= d_addr_in;
            mem_wdata_out <= d_wdata_in;
            mem_size_out  <= d_size_in;
         end
      end
   end
   // memory read result is already registered, so return data is a pure wire
   assign i_rdata_out  = mem_rdata_in;
   assign d_rdata_out  = mem_rdata_in;
   assign i_rvalid_out = tag_ret == OWN_I;
   assign d_rvalid_out = tag_ret == OWN_D;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters against a transaction-level model of the arbiter
module tb_mem_arbiter;
   import mem_arb_pkg::*;
   localparam int SM = 4;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic i_req_in = 1'b0, d_req_in = 1'b0, d_we_in = 1'b0;
   logic [31:0] i_addr_in = '0, d_addr_in = '0, d_wdata_in = '0;
   logic [1:0] d_size_in = '0;
   logic i_gnt_out, i_rvalid_out, d_gnt_out, d_rvalid_out, mem_re_out, mem_we_out;
   logic [31:0] i_rdata_out, d_rdata_out, mem_addr_out, mem_wdata_out;
   logic [31:0] mem_rdata_in = '0;
   logic [1:0] mem_size_out;
   int n_chk = 0, n_err = 0;
   always #5 clock = ~clock;
   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
      .clock(clock), .reset(reset),
      .i_req_in(i_req_in), .i_addr_in(i_addr_in), .i_gnt_out(i_gnt_out),
      .i_rvalid_out(i_rvalid_out), .i_rdata_out(i_rdata_out),
      .d_req_in(d_req_in), .d_we_in(d_we_in), .d_addr_in(d_addr_in),
      .d_wdata_in(d_wdata_in), .d_size_in(d_size_in), .d_gnt_out(d_gnt_out),
      .d_rvalid_out(d_rvalid_out), .d_rdata_out(d_rdata_out),
      .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
      .mem_re_out(mem_re_out), .mem_we_out(mem_we_out),
      .mem_size_out(mem_size_out), .mem_rdata_in(mem_rdata_in)
   );
   function automatic logic [31:0] init_val(input int idx);
      return 32'hA5C30000 ^ (idx * 32'h01010101);
   endfunction
   // behavioural data_memory: registered read, write at the edge
   logic [31:0] mem [64];
   logic [63:0] written = '0;
   always @(posedge clock) begin
      if (mem_we_out) begin
         mem[mem_addr_out[7:2]] <= mem_wdata_out;
         written[mem_addr_out[7:2]] <= 1'b1;
      end
      if (mem_re_out)
         mem_rdata_in <= written[mem_addr_out[7:2]] ? mem[mem_addr_out[7:2]] : init_val(int'(mem_addr_out[7:2]));
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   typedef struct {owner_t o; logic [31:0] d;} rv_t;
   initial begin
      logic [31:0] shadow [64];
      rv_t rvq [$];
      rv_t r;
      int denied, pct;
      logic exp_i, exp_d, m_re, m_we;
      logic [31:0] m_addr, m_wdata;
      logic [1:0] m_size;
      for (int j = 0; j < 64; j++) shadow[j] = init_val(j);
      rvq = '{'{OWN_NONE, 32'h0}, '{OWN_NONE, 32'h0}};
      denied = 0;
      m_re = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_size = SIZE_WORD;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clock);
         #1;
         chk("mem_re", 32'(mem_re_out), 32'(m_re));
         chk("mem_we", 32'(mem_we_out), 32'(m_we));
         chk("mem_addr", mem_addr_out, m_addr);
         chk("mem_wdata", mem_wdata_out, m_wdata);
         chk("mem_size", 32'(mem_size_out), 32'(m_size));
         r = rvq.pop_front();
         chk("i_rvalid", 32'(i_rvalid_out), 32'(r.o == OWN_I));
         chk("d_rvalid", 32'(d_rvalid_out), 32'(r.o == OWN_D));
         if (r.o == OWN_I) chk("i_rdata", i_rdata_out, r.d);
         if (r.o == OWN_D) chk("d_rdata", d_rdata_out, r.d);
         pct = (c / 400) % 4 == 0 ? 100 : (c / 400) % 4 == 1 ? 60 : (c / 400) % 4 == 2 ? 30 : 85;
         reset = !(c < 2 || $urandom_range(99) < 2);
         // requesters hold request and payload until granted
         if (!i_req_in || i_gnt_out) begin
            i_req_in = $urandom_range(99) < pct;
            i_addr_in = {24'h0, 6'($urandom), 2'b00};
         end
         if (!d_req_in || d_gnt_out) begin
            d_req_in = $urandom_range(99) < pct;
            d_we_in = $urandom_range(2) == 0;
            d_addr_in = {24'h0, 6'($urandom), 2'b00};
            d_wdata_in = $urandom;
            d_size_in = 2'($urandom);
         end
         #1;
         exp_i = reset && i_req_in && (!d_req_in || denied == SM);
         exp_d = reset && d_req_in && !exp_i;
         chk("i_gnt", 32'(i_gnt_out), 32'(exp_i));
         chk("d_gnt", 32'(d_gnt_out), 32'(exp_d));
         denied = (!reset || !i_req_in || exp_i) ? 0 : (denied == SM ? SM : denied + 1);
         if (exp_i) begin
            m_re = 1; m_we = 0; m_addr = i_addr_in; m_wdata = 0; m_size = SIZE_WORD;
            rvq.push_back('{OWN_I, shadow[i_addr_in[7:2]]});
         end else if (exp_d) begin
            m_re = !d_we_in; m_we = d_we_in; m_addr = d_addr_in; m_wdata = d_wdata_in; m_size = d_size_in;
            if (d_we_in) begin
               shadow[d_addr_in[7:2]] = d_wdata_in;
               rvq.push_back('{OWN_NONE, 32'h0});
            end else
               rvq.push_back('{OWN_D, shadow[d_addr_in[7:2]]});
         end else begin
            m_re = 0; m_we = 0;
            rvq.push_back('{OWN_NONE, 32'h0});
         end
         if (!reset) begin
            m_re = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_size = SIZE_WORD;
            rvq = '{'{OWN_NONE, 32'h0}, '{OWN_NONE, 32'h0}};
         end
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port `data_memory` between the instruction-fetch path and the load/store path of the lab processor. It grants one access per cycle and registers the winning request onto the memory's `addr_in`/`writedata_in`/`re_in`/`we_in`/`size_in`. It steers `readdata_out` back to the owning requester with a valid strobe. Fixed priority favours the data port, and a starvation counter guarantees fetch progress.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive denied fetch cycles before fetch is forced to win (>=1)

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `i_req_in`  in  1  fetch request
- `i_addr_in`  in  ADDR_W  fetch address
- `i_gnt_out`  out  1  fetch granted this cycle
- `i_rvalid_out`  out  1  fetch read data valid
- `i_rdata_out`  out  DATA_W  fetch read data
- `d_req_in`  in  1  load/store request
- `d_we_in`  in  1  1 = store, 0 = load
- `d_addr_in`  in  ADDR_W  load/store address
- `d_wdata_in`  in  DATA_W  store data
- `d_size_in`  in  2  access size, forwarded unchanged
- `d_gnt_out`  out  1  load/store granted this cycle
- `d_rvalid_out`  out  1  load data valid (never for stores)
- `d_rdata_out`  out  DATA_W  load data
- `mem_addr_out`  out  ADDR_W  to memory `addr_in`
- `mem_wdata_out`  out  DATA_W  to memory `writedata_in`
- `mem_re_out`  out  1  to memory `re_in`
- `mem_we_out`  out  1  to memory `we_in`
- `mem_size_out`  out  2  to memory `size_in`
- `mem_rdata_in`  in  DATA_W  from memory `readdata_out`

## Operation
- Grant is combinational from the current requests, registered state and `reset`. It is at most one-hot, and never asserted while `reset`=0.
- Priority:
  - Only one request: that request wins.
  - Both requests: data wins unless `starve_cnt`==`STARVE_MAX`, in which case fetch wins.
- `starve_cnt`, width clog2(`STARVE_MAX`+1):
  - +1 when `i_req_in`=1 and `i_gnt_out`=0, saturating at `STARVE_MAX`.
  - Cleared when `i_gnt_out`=1 or `i_req_in`=0.
- Request capture:
  - The granted request is captured into the memory-side registers at the edge.
  - Fetch issues re=1, we=0, size=2'b11, wdata=0.
  - Data issues re=!we, we=d_we_in, size=d_size_in, wdata=d_wdata_in.
- Owner tag (NONE/I/D) is pipelined alongside the request for read-data return; stores carry tag NONE.
- Read data is passed combinationally from `mem_rdata_in` to both `*_rdata_out`. Only the tagged owner's rvalid is asserted.
- Requesters hold req and payload stable until they see gnt. The arbiter does not buffer ungranted requests.
- Grants are back-to-back capable: one grant per cycle, pipelined, with no idle cycle between accesses.

## Timing
- Cycle N: req=1 and gnt=1 (combinational).
- Cycle N+1: `mem_*_out` carry the request, with re/we high for exactly this cycle.
- Cycle N+2: the memory's registered read result appears on `mem_rdata_in`; owner rvalid=1 for one cycle. Read latency is 2 cycles from grant.
- With no grant in cycle N, in cycle N+1 `mem_re_out`=`mem_we_out`=0, and addr/wdata/size hold their previous values.
- Reset (`reset`=0 at an edge) values after the edge:
  - `mem_re_out`=0, `mem_we_out`=0
  - `mem_addr_out`=0, `mem_wdata_out`=0, `mem_size_out`=2'b11
  - both rvalid=0, all tags NONE, `starve_cnt`=0
- Reset mid-operation: in-flight tags are discarded, and no rvalid is asserted for accesses granted before reset. The first grant is possible in the first cycle with `reset`=1.
- Store followed by load to the same address in consecutive cycles: the load returns the stored data. Memory write-then-read ordering is preserved because issue is in order.

## Structure
- Package `mem_arb_pkg`:
  - owner enum `OWN_NONE`/`OWN_I`/`OWN_D`
  - constant `SIZE_WORD`=2'b11
- Sub-module `mem_arb_prio`: combinational priority plus `starve_cnt` register, producing the two grants.
- The top level holds the capture registers and the tag pipeline.

## Test plan
- Fetch only, address 0x10, memory word 0xDEADBEEF → gnt in N, re=1/addr=0x10 in N+1, `i_rvalid_out`=1 with data 0xDEADBEEF in N+2, `d_rvalid_out`=0.
- Store 0xCAFEF00D to 0x20, then load 0x20 on the next cycle → we=1 then re=1 on consecutive cycles; `d_rdata_out`=0xCAFEF00D with `d_rvalid_out`=1 two cycles after the load grant; no rvalid for the store.
- Both requesting continuously, `STARVE_MAX`=4 → data granted cycles 0–3, fetch cycle 4, data cycles 5–8, fetch cycle 9.
- Interleaved fetch and load grants on alternate cycles → each rvalid goes only to its owner, in order, with no dropped or duplicated strobes.
- `reset`=0 asserted the cycle after a load grant → no `d_rvalid_out` afterwards; all outputs at reset values; a new fetch after reset completes in 2 cycles.
- Requests with `reset`=0 → both grants 0, `mem_re_out`=`mem_we_out`=0.
